uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
Shares one UART transmitter among NUM_REQ byte-producing requesters, e.g. auth ack, telemetry and fault reporter. Runs arbitration and sequences the transmitter's trmt/tx_done handshake. Enforces a minimum inter-byte gap and recovers from a hung transmitter with a watchdog. Sits between the BLE-side producers and the UART_tx instance in the segway top level.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
PRIO0_EN, 1, 1 = requester 0 has strict priority over the others; 0 = pure round-robin over all
GAP_CYC, 16, idle clocks forced after each completed or aborted byte (>=1)
TIMEOUT_CYC, 65536, clocks allowed in WAIT_DONE before abort (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable (tie to pwr_up); low blocks new grants only
req  in  NUM_REQ  per-requester byte-pending level
req_data  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
gnt  out  NUM_REQ  one-hot, 1-cycle pulse: byte accepted, requester may drop req/change data next cycle
done  out  NUM_REQ  one-hot, 1-cycle pulse: granted byte fully transmitted
trmt  out  1  1-cycle start pulse to UART_tx
tx_data  out  8  byte to UART_tx, stable from trmt until state leaves WAIT_DONE
tx_done  in  1  UART_tx completion (level or pulse; first high cycle in WAIT_DONE counts)
err_timeout  out  1  1-cycle pulse on watchdog abort
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, gnt=0, done=0, trmt=0, tx_data=8'h00, err_timeout=0, busy=0, owner=0, RR pointer last=NUM_REQ-1 so the first RR search begins at index 0; counters cleared. All outputs are registered.
- States: IDLE, LOAD, WAIT_DONE, GAP.
- IDLE: if en && |req at edge N, winner chosen combinationally. At N:
  - owner and tx_data latch
  - state goes to LOAD
  - gnt[winner]=1 during cycle N+1
- Arbitration:
  - If PRIO0_EN and req[0], winner=0 and the RR pointer is unchanged.
  - Otherwise, first asserted req scanning last+1, last+2, ... (mod NUM_REQ), excluding index 0 when PRIO0_EN. last is updated to the winner.
- LOAD: trmt=1 for exactly this cycle (N+1). The next state is WAIT_DONE unconditionally. tx_done is ignored in LOAD.
- WAIT_DONE:
  - The watchdog counts from 0.
  - If tx_done, done[owner] pulses the next cycle and the state goes to GAP.
  - Else if count==TIMEOUT_CYC-1, err_timeout pulses the next cycle, no done is issued, and the state goes to GAP. The aborted byte is dropped and not retried.
- GAP: stay exactly GAP_CYC cycles, then return to IDLE. req is not sampled during GAP.
- Minimum grant-to-grant spacing with immediate tx_done: 1 (LOAD) + 1 (WAIT_DONE) + GAP_CYC + 1 (IDLE) clocks.
- en deasserted: has effect only in IDLE (no grant). A byte in flight always completes or times out.
- req dropped before grant: nothing is sent and no state change occurs. A req held after gnt is treated as a new byte at the next IDLE.
- Simultaneous tx_done and timeout terminal count: tx_done wins (done, no error).
- Reset mid-transfer: immediate return to reset values. No done/err pulse is issued for the lost byte.
- Width: watchdog counter is $clog2(TIMEOUT_CYC+1) bits, gap counter is $clog2(GAP_CYC+1) bits, owner is $clog2(NUM_REQ) bits (min 1).

Decomposition:
- Package uart_sched_pkg: state enum sched_state_t {IDLE, LOAD, WAIT_DONE, GAP}, MAX_REQ=8 constant.
- One sub-module, rr_arbiter: req, prio0_en and last pointer in; one-hot grant and index out; purely combinational. It is reused by future shared-resource blocks. FSM, counters and datapath registers stay in uart_tx_sched.

Test Plan:
- Single req[1]=1, data 8'h47, tx_done 10 cycles after trmt -> gnt[1] then trmt on the same cycle, tx_data=8'h47, done[1] 1 cycle after tx_done, busy low after GAP_CYC.
- req=3'b110 held, PRIO0_EN=1, immediate tx_done -> grants in order 1,2,1,2. Assert req[0] mid-sequence -> req[0] granted next, RR order resumes at the saved pointer.
- PRIO0_EN=0, req=3'b111 held -> grants 0,1,2,0. Grant-to-grant spacing exactly GAP_CYC+3 cycles.
- tx_done never asserted, TIMEOUT_CYC=100 -> err_timeout pulse 100 cycles after entering WAIT_DONE, no done, next grant proceeds normally after GAP.
- en=0 with req[2]=1 -> no gnt/trmt. Drop en mid-WAIT_DONE -> the in-flight byte still yields done. Raise en -> req[2] granted.
- Assert rst_n=0 during WAIT_DONE -> all outputs at reset values, no done/err. After release, the first RR grant goes to the lowest pending index.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int MAX_REQ = 8;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter with optional strict priority for index 0.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic          prio0_en,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    if (prio0_en && req[0]) begin
      gnt[0] = 1'b1;
      found  = 1'b1;
    end
    // Scan starts just after the last RR winner; index 0 is skipped in priority mode.
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!found && req[c[IW-1:0]] && !(prio0_en && c == 0)) begin
        gnt[c[IW-1:0]] = 1'b1;
        idx            = c[IW-1:0];
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates byte requesters onto one UART transmitter, sequencing trmt/tx_done
// with an enforced inter-byte gap and a watchdog against a hung transmitter.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter bit PRIO0_EN    = 1'b1,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 trmt,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic                 err_timeout,
  output logic                 busy
);

  localparam int OW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [WD_W-1:0]  WD_TC  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_CYC - 1);

  sched_state_t       state;
  logic [OW-1:0]      owner;
  logic [OW-1:0]      last;
  logic [WD_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [OW-1:0]      arb_idx;

  rr_arbiter #(.N(NUM_REQ), .IW(OW)) u_arb (
    .req      (req),
    .prio0_en (PRIO0_EN),
    .last     (last),
    .gnt      (arb_gnt),
    .idx      (arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= '0;
      last        <= OW'(NUM_REQ - 1);
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      gnt         <= '0;
      done        <= '0;
      trmt        <= 1'b0;
      tx_data     <= 8'h00;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gnt         <= '0;
      done        <= '0;
      trmt        <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && |req) begin
            owner   <= arb_idx;
            tx_data <= req_data[8*int'(arb_idx) +: 8];
            gnt     <= arb_gnt;
            trmt    <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
            // A priority win on index 0 leaves the round-robin pointer alone.
            if (!(PRIO0_EN && arb_idx == '0)) last <= arb_idx;
          end
        end
        LOAD: begin
          wd_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            done    <= NUM_REQ'(1) << owner;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (wd_cnt == WD_TC) begin
            err_timeout <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_TC) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: instance A uses priority mode, instance B pure round-robin.
module tb_uart_tx_sched;

  localparam int G     = 4;
  localparam int TO    = 100;
  localparam int SPACE = G + 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [23:0] req_data;
  logic [2:0]  req_a, req_b;
  logic        tx_done_a, tx_done_b;
  logic [2:0]  gnt_a, gnt_b, done_a, done_b;
  logic        trmt_a, trmt_b, err_a, err_b, busy_a, busy_b;
  logic [7:0]  tx_data_a, tx_data_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.NUM_REQ(3), .PRIO0_EN(1'b1), .GAP_CYC(G), .TIMEOUT_CYC(TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_a), .req_data(req_data),
    .gnt(gnt_a), .done(done_a), .trmt(trmt_a), .tx_data(tx_data_a),
    .tx_done(tx_done_a), .err_timeout(err_a), .busy(busy_a)
  );

  uart_tx_sched #(.NUM_REQ(3), .PRIO0_EN(1'b0), .GAP_CYC(G), .TIMEOUT_CYC(TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req_b), .req_data(req_data),
    .gnt(gnt_b), .done(done_b), .trmt(trmt_b), .tx_data(tx_data_b),
    .tx_done(tx_done_b), .err_timeout(err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit sel_b, input int budget,
                          output logic [2:0] g, output int n);
    g = 3'b000;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      tick();
      n = i;
      g = sel_b ? gnt_b : gnt_a;
      if (g != 3'b000) return;
    end
  endtask

  task automatic wait_idle(input bit sel_b);
    for (int i = 0; i < 200; i++) begin
      if (!(sel_b ? busy_b : busy_a)) break;
      tick();
    end
    chk("idle_reached", {31'd0, sel_b ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    logic [2:0] g;
    int         n;
    logic       seen;

    rst_n     = 1'b0;
    en        = 1'b1;
    req_data  = {8'h33, 8'h47, 8'h11};
    req_a     = 3'b000;
    req_b     = 3'b000;
    tx_done_a = 1'b0;
    tx_done_b = 1'b0;
    tick();
    tick();
    chk("rst_gnt",  {29'd0, gnt_a}, 32'd0);
    chk("rst_done", {29'd0, done_a}, 32'd0);
    chk("rst_trmt", {31'd0, trmt_a}, 32'd0);
    chk("rst_data", {24'd0, tx_data_a}, 32'd0);
    chk("rst_err",  {31'd0, err_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    rst_n = 1'b1;

    // Single requester, tx_done 10 cycles after trmt
    req_a = 3'b010;
    tick();
    chk("t1_gnt",  {29'd0, gnt_a}, 32'b010);
    chk("t1_trmt", {31'd0, trmt_a}, 32'd1);
    chk("t1_data", {24'd0, tx_data_a}, 32'h47);
    chk("t1_busy", {31'd0, busy_a}, 32'd1);
    req_a = 3'b000;
    tick();
    chk("t1_trmt_off", {31'd0, trmt_a}, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    tx_done_a = 1'b1;
    tick();
    tx_done_a = 1'b0;
    chk("t1_done", {29'd0, done_a}, 32'b010);
    chk("t1_data_hold", {24'd0, tx_data_a}, 32'h47);
    tick();
    chk("t1_done_off", {29'd0, done_a}, 32'd0);
    tick();
    tick();
    chk("t1_busy_gap", {31'd0, busy_a}, 32'd1);
    tick();
    chk("t1_busy_end", {31'd0, busy_a}, 32'd0);

    // Priority mode RR over 1,2 with a req[0] intrusion
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_a = 3'b110;
    tx_done_a = 1'b1;
    wait_gnt(1'b0, 20, g, n);
    chk("t2_g0", {29'd0, g}, 32'b010);
    wait_gnt(1'b0, 20, g, n);
    chk("t2_g1", {29'd0, g}, 32'b100);
    chk("t2_sp1", n, SPACE);
    req_a = 3'b111;
    wait_gnt(1'b0, 20, g, n);
    chk("t2_g2_prio", {29'd0, g}, 32'b001);
    chk("t2_data_prio", {24'd0, tx_data_a}, 32'h11);
    req_a = 3'b110;
    wait_gnt(1'b0, 20, g, n);
    chk("t2_g3", {29'd0, g}, 32'b010);
    wait_gnt(1'b0, 20, g, n);
    chk("t2_g4", {29'd0, g}, 32'b100);
    chk("t2_sp4", n, SPACE);
    req_a = 3'b000;
    wait_idle(1'b0);

    // Watchdog abort
    tx_done_a = 1'b0;
    req_a = 3'b100;
    wait_gnt(1'b0, 5, g, n);
    chk("t3_gnt", {29'd0, g}, 32'b100);
    chk("t3_data", {24'd0, tx_data_a}, 32'h33);
    req_a = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      seen = seen | err_a | (|done_a);
    end
    chk("t3_early", {31'd0, seen}, 32'd0);
    tick();
    chk("t3_err", {31'd0, err_a}, 32'd1);
    chk("t3_nodone", {29'd0, done_a}, 32'd0);
    req_a = 3'b010;
    tx_done_a = 1'b1;
    wait_gnt(1'b0, 20, g, n);
    chk("t3_next_gnt", {29'd0, g}, 32'b010);
    chk("t3_next_sp", n, G + 1);
    req_a = 3'b000;
    wait_idle(1'b0);

    // Enable gating
    tx_done_a = 1'b0;
    req_a = 3'b100;
    wait_gnt(1'b0, 5, g, n);
    chk("t4_gnt", {29'd0, g}, 32'b100);
    en = 1'b0;
    tick();
    tick();
    tx_done_a = 1'b1;
    tick();
    tx_done_a = 1'b0;
    chk("t4_done", {29'd0, done_a}, 32'b100);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | trmt_a | (|gnt_a);
    end
    chk("t4_blocked", {31'd0, seen}, 32'd0);
    en = 1'b1;
    wait_gnt(1'b0, 5, g, n);
    chk("t4_regnt", {29'd0, g}, 32'b100);
    chk("t4_regnt_lat", n, 1);
    req_a = 3'b000;
    tx_done_a = 1'b1;
    wait_idle(1'b0);

    // Reset during WAIT_DONE
    tx_done_a = 1'b0;
    req_a = 3'b010;
    wait_gnt(1'b0, 5, g, n);
    chk("t5_gnt", {29'd0, g}, 32'b010);
    req_a = 3'b000;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy_a}, 32'd0);
    chk("t5_data", {24'd0, tx_data_a}, 32'd0);
    chk("t5_trmt", {31'd0, trmt_a}, 32'd0);
    tx_done_a = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | err_a | (|done_a);
    end
    chk("t5_no_pulse", {31'd0, seen}, 32'd0);
    tx_done_a = 1'b0;
    rst_n = 1'b1;
    req_a = 3'b110;
    wait_gnt(1'b0, 5, g, n);
    chk("t5_first", {29'd0, g}, 32'b010);
    req_a = 3'b000;
    tx_done_a = 1'b1;
    wait_idle(1'b0);

    // Pure round-robin over all three
    req_b = 3'b111;
    tx_done_b = 1'b1;
    wait_gnt(1'b1, 5, g, n);
    chk("b_g0", {29'd0, g}, 32'b001);
    tick();
    tick();
    chk("b_done0", {29'd0, done_b}, 32'b001);
    wait_gnt(1'b1, 20, g, n);
    chk("b_g1", {29'd0, g}, 32'b010);
    chk("b_sp1", n, G + 1);
    wait_gnt(1'b1, 20, g, n);
    chk("b_g2", {29'd0, g}, 32'b100);
    chk("b_sp2", n, SPACE);
    chk("b_data2", {24'd0, tx_data_b}, 32'h33);
    wait_gnt(1'b1, 20, g, n);
    chk("b_g3", {29'd0, g}, 32'b001);
    chk("b_sp3", n, SPACE);
    req_b = 3'b000;
    wait_idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
